// File: rtl/conv_seq.sv
// conv_seq: sequences one convolution layer pass.
// It reads the weights and then the pixels out of a shared buffer and streams
// them to the conv engine. It counts the engine results until the expected
// number has arrived, then pulses done.
// Pixel issue is throttled by out_ready. A pass can be cancelled with abort.
module conv_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_w_cnt,
  input  logic [ADDR_W-1:0] cfg_p_cnt,
  input  logic [ADDR_W-1:0] cfg_o_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] w,
  output logic              w_valid,
  output logic [DATA_W-1:0] p,
  output logic              p_valid,
  input  logic              o_valid,
  input  logic              out_ready,
  output logic              o_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_P,
    DRAIN,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t state, state_nxt;

  // Word counts captured at start, so the config inputs may change mid-pass.
  logic [ADDR_W-1:0] w_num, p_num, o_num;

  // addr runs across both phases, so the pixel addresses continue straight on
  // from the last weight address and wrap modulo 2^ADDR_W.
  // phase_cnt counts the reads issued in the current phase only.
  logic [ADDR_W-1:0] addr, phase_cnt, phase_len;
  logic [ADDR_W-1:0] o_cnt;

  // Tags for the read in flight. The buffer answers one cycle after rd_en.
  logic w_vld_q, p_vld_q;

  logic launch, kill, phase_end, counting, o_full;

  assign launch    = (state == IDLE) && start && !abort;
  assign kill      = (state != IDLE) && abort;
  assign counting  = state inside {LOAD_W, LOAD_P, DRAIN};
  assign o_full    = (o_cnt == o_num);
  assign phase_len = (state == LOAD_W) ? w_num : p_num;
  assign phase_end = rd_en && (phase_cnt == phase_len - ONE);

  // Read issue: one word per cycle for the weights, gated by out_ready for
  // the pixels. An abort stops any read in the cycle it is seen.
  always_comb begin
    // NOTE: give every combinationally written signal a default at the top of
    // the block; a path that leaves it unassigned would infer a latch.
    rd_en = 1'b0;
    case (state)
      LOAD_W:  rd_en = !abort;
      LOAD_P:  rd_en = out_ready && !abort;
      default: rd_en = 1'b0;
    endcase
  end

  assign rd_addr = rd_en ? addr : '0;

  // Next-state and done decode. A zero count skips its phase. DRAIN is always
  // visited, and with nothing left to wait for it exits after one cycle.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          if (cfg_w_cnt != '0)      state_nxt = LOAD_W;
          else if (cfg_p_cnt != '0) state_nxt = LOAD_P;
          else                      state_nxt = DRAIN;
        end
      end
      LOAD_W: begin
        if (phase_end) state_nxt = (p_num != '0) ? LOAD_P : DRAIN;
      end
      LOAD_P: begin
        if (phase_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (o_full) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a pending done.
    if (kill) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and the block order cannot change the result.
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  // Capture the pass configuration when a start is accepted.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_num <= '0;
      p_num <= '0;
      o_num <= '0;
    end else if (launch) begin
      w_num <= cfg_w_cnt;
      p_num <= cfg_p_cnt;
      o_num <= cfg_o_cnt;
    end
  end

  // Address, phase and output counters. They clear on launch, on abort and
  // at the end of a pass. The output counter saturates at the expected count.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      addr      <= '0;
      phase_cnt <= '0;
      o_cnt     <= '0;
    end else if (launch || kill || (state == FIN)) begin
      addr      <= '0;
      phase_cnt <= '0;
      o_cnt     <= '0;
    end else begin
      if (rd_en) begin
        addr      <= addr + ONE;
        phase_cnt <= phase_end ? '0 : phase_cnt + ONE;
      end
      if (counting && o_valid && !o_full) o_cnt <= o_cnt + ONE;
    end
  end

  // Tag each issued read as a weight or a pixel for the cycle its data returns.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_vld_q <= 1'b0;
      p_vld_q <= 1'b0;
    end else begin
      w_vld_q <= rd_en && (state == LOAD_W);
      p_vld_q <= rd_en && (state == LOAD_P);
    end
  end

  // The data path is the buffer output, forced to zero when no word is valid.
  // A read still in flight when abort arrives is dropped here.
  assign w_valid = w_vld_q && !abort;
  assign p_valid = p_vld_q && !abort;
  assign w       = w_valid ? rd_data : '0;
  assign p       = p_valid ? rd_data : '0;

  assign o_last  = counting && o_valid && (o_num != '0) && (o_cnt == o_num - ONE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: scoreboard bench for conv_seq.
// Each scenario queues the read addresses and the weight and pixel words it
// expects. A negedge monitor pops the queues and compares them with the DUT
// outputs.
module tb_conv_seq;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              s_axi_aclk = 1'b0;
  logic              s_axi_aresetn;
  logic              start, abort, o_valid, out_ready;
  logic [ADDR_W-1:0] cfg_w_cnt, cfg_p_cnt, cfg_o_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] w, p;
  logic              w_valid, p_valid, o_last, busy, done;

  conv_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .start        (start),
    .abort        (abort),
    .cfg_w_cnt    (cfg_w_cnt),
    .cfg_p_cnt    (cfg_p_cnt),
    .cfg_o_cnt    (cfg_o_cnt),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .w            (w),
    .w_valid      (w_valid),
    .p            (p),
    .p_valid      (p_valid),
    .o_valid      (o_valid),
    .out_ready    (out_ready),
    .o_last       (o_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int cyc = 0;
  always @(posedge s_axi_aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Buffer contents: a distinct word per address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ {a, 12'h5A5, a};
  endfunction

  // Buffer model: data is returned one cycle after the read strobe.
  always @(posedge s_axi_aclk) rd_data <= rd_en ? mem_word(rd_addr) : '0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_w[$];
  logic [DATA_W-1:0] exp_p[$];
  bit contig = 0;
  bit no_rd  = 0;
  int last_rd = -1;
  int done_seen = 0;

  // Scoreboard monitor.
  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn) begin
      if (rd_en) begin
        if (exp_addr.size() == 0) check("rd_extra", rd_en, 0);
        else                      check("rd_addr", rd_addr, exp_addr.pop_front());
        if (contig && last_rd >= 0) check("rd_gap", cyc - last_rd, 1);
        last_rd = cyc;
      end
      if (no_rd) check("rd_paused", rd_en, 0);
      if (w_valid) begin
        if (exp_w.size() == 0) check("w_extra", w_valid, 0);
        else                   check("w_data", w, exp_w.pop_front());
      end
      if (p_valid) begin
        if (exp_p.size() == 0) check("p_extra", p_valid, 0);
        else                   check("p_data", p, exp_p.pop_front());
      end
      if (w_valid || p_valid) check("wp_excl", w_valid & p_valid, 0);
      if (done) done_seen++;
    end
  end

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic load_exp(input int nw, input int np);
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      exp_w.push_back(mem_word(ADDR_W'(i)));
    end
    for (int i = 0; i < np; i++) begin
      exp_addr.push_back(ADDR_W'(nw + i));
      exp_p.push_back(mem_word(ADDR_W'(nw + i)));
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] wc, input logic [ADDR_W-1:0] pc,
                             input logic [ADDR_W-1:0] oc);
    cfg_w_cnt = wc;
    cfg_p_cnt = pc;
    cfg_o_cnt = oc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string tag);
    int n = 0;
    while ((exp_w.size() + exp_p.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_w.size() + exp_p.size(), 0);
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a, input string tag);
    bit hit = 0;
    int n = 0;
    while (!hit && n < 30) begin
      @(negedge s_axi_aclk);
      hit = rd_en && (rd_addr == a);
      n++;
    end
    check(tag, hit, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit hit = 0;
    int n = 0;
    while (!hit && n < budget) begin
      @(negedge s_axi_aclk);
      hit = done;
      n++;
    end
    check(tag, hit, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    s_axi_aresetn = 1'b0;
    start = 0; abort = 0; o_valid = 0; out_ready = 1;
    cfg_w_cnt = '0; cfg_p_cnt = '0; cfg_o_cnt = '0;
    repeat (2) @(posedge s_axi_aclk);
    #1;
    check("rst_ctl", {rd_en, rd_addr, w_valid, p_valid, o_last, busy, done}, 0);
    check("rst_data", {w, p}, 0);
    s_axi_aresetn = 1'b1;

    // Scenario 1: W=4 P=8 O=2. The start is issued right after the reset release.
    load_exp(4, 8);
    contig = 1;
    d = done_seen;
    pulse_start(10'd4, 10'd8, 10'd2);
    @(negedge s_axi_aclk);
    check("s1_busy", busy, 1);
    cfg_w_cnt = 10'd7; cfg_p_cnt = 10'd1; cfg_o_cnt = 10'd9;  // ignored mid-pass
    wait_empty(40, "s1_data");
    contig = 0;
    check("s1_addr_left", exp_addr.size(), 0);
    o_valid = 1;
    @(negedge s_axi_aclk);
    check("s1_olast_a", o_last, 0);
    tick();
    @(negedge s_axi_aclk);
    check("s1_olast_b", o_last, 1);
    tick();
    o_valid = 0;
    @(negedge s_axi_aclk);
    check("s1_done_early", done, 0);
    check("s1_busy_drain", busy, 1);
    tick();
    @(negedge s_axi_aclk);
    check("s1_done", done, 1);
    tick();
    @(negedge s_axi_aclk);
    check("s1_done_len", done, 0);
    check("s1_idle", busy, 0);
    check("s1_done_cnt", done_seen - d, 1);

    // Scenario 2: W=2 P=6 O=1, with out_ready low for 3 cycles after the 2nd pixel read.
    tick();
    load_exp(2, 6);
    pulse_start(10'd2, 10'd6, 10'd1);
    wait_rd(10'd3, "s2_px2");
    tick();
    out_ready = 0;
    no_rd = 1;
    repeat (3) tick();
    out_ready = 1;
    no_rd = 0;
    wait_empty(30, "s2_data");
    check("s2_addr_left", exp_addr.size(), 0);
    o_valid = 1;
    @(negedge s_axi_aclk);
    check("s2_olast", o_last, 1);
    tick();
    o_valid = 0;
    wait_done(10, "s2_done");
    tick();

    // Scenario 3: all counts zero. done is expected 2 cycles after start, with no reads.
    d = done_seen;
    pulse_start(10'd0, 10'd0, 10'd0);
    @(negedge s_axi_aclk);
    check("s3_done_early", done, 0);
    check("s3_busy", busy, 1);
    tick();
    @(negedge s_axi_aclk);
    check("s3_done", done, 1);
    tick();
    @(negedge s_axi_aclk);
    check("s3_idle", busy, 0);
    check("s3_done_cnt", done_seen - d, 1);

    // Scenario 4: abort during LOAD_P while the read of address 4 is in flight.
    tick();
    d = done_seen;
    for (int i = 0; i < 5; i++) exp_addr.push_back(ADDR_W'(i));
    exp_w.push_back(mem_word(10'd0));
    exp_w.push_back(mem_word(10'd1));
    exp_p.push_back(mem_word(10'd2));
    exp_p.push_back(mem_word(10'd3));
    pulse_start(10'd2, 10'd8, 10'd1);
    wait_rd(10'd4, "s4_px");
    tick();
    abort = 1;
    @(negedge s_axi_aclk);
    check("s4_inflight", p_valid, 0);
    tick();
    abort = 0;
    @(negedge s_axi_aclk);
    check("s4_busy", busy, 0);
    repeat (5) tick();
    check("s4_no_done", done_seen - d, 0);
    check("s4_left", exp_addr.size() + exp_w.size() + exp_p.size(), 0);
    load_exp(1, 1);
    pulse_start(10'd1, 10'd1, 10'd0);
    wait_done(10, "s4_restart");
    tick();
    check("s4_restart_left", exp_addr.size() + exp_p.size(), 0);

    // Scenario 5: reset pulsed low during DRAIN.
    d = done_seen;
    load_exp(1, 1);
    pulse_start(10'd1, 10'd1, 10'd3);
    wait_empty(10, "s5_data");
    o_valid = 1;
    tick();
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    check("s5_rst_ctl", {rd_en, rd_addr, w_valid, p_valid, o_last, busy, done}, 0);
    check("s5_rst_data", {w, p}, 0);
    o_valid = 0;
    repeat (2) @(posedge s_axi_aclk);
    #1;
    check("s5_no_done", done_seen - d, 0);
    s_axi_aresetn = 1'b1;

    // Scenario 6: a stray o_valid in IDLE and a second start while busy are both ignored.
    d = done_seen;
    load_exp(2, 2);
    o_valid = 1;
    pulse_start(10'd2, 10'd2, 10'd2);
    o_valid = 0;
    cfg_w_cnt = 10'd5; cfg_p_cnt = 10'd5; cfg_o_cnt = 10'd5;
    start = 1;
    tick();
    start = 0;
    wait_empty(20, "s6_data");
    o_valid = 1;
    @(negedge s_axi_aclk);
    check("s6_olast_a", o_last, 0);
    tick();
    @(negedge s_axi_aclk);
    check("s6_olast_b", o_last, 1);
    tick();
    @(negedge s_axi_aclk);
    check("s6_olast_sat", o_last, 0);
    check("s6_done_early", done, 0);
    tick();
    o_valid = 0;
    @(negedge s_axi_aclk);
    check("s6_done", done, 1);
    tick();
    @(negedge s_axi_aclk);
    check("s6_idle", busy, 0);
    repeat (5) tick();
    check("s6_still_idle", busy, 0);
    check("s6_done_cnt", done_seen - d, 1);
    check("s6_left", exp_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
